// File: rtl/uart_pkg.sv
// Shared types for the UART receiver. The PARITY state exists in every build
// so state encodings stay identical with or without UART_RX_PARITY_EN.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so that idle-high lines come out of reset inactive.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// Define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge on rxs
// START   | half-bit wait, then confirm the start bit (reject glitches)
// DATA    | sample 8 data bits, LSB first, one per bit period
// PARITY  | sample the parity bit (reachable only with UART_RX_PARITY_EN)
// STOP    | sample the stop bit; deliver the byte or flag a framing error
// RECOVER | stop bit was 0; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic PARITY_SENSE = (PARITY_ODD != 0);

`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

    uart_rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]          clk_cnt, clk_cnt_nxt;
    logic [2:0]                bit_cnt, bit_cnt_nxt;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                      parity_bad, parity_bad_nxt;
    logic                      deliver;
    logic                      frame_err_nxt;
    logic                      rxs;
    logic                      tc;
    logic                      accept;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    assign tc     = (clk_cnt == '0);
    assign accept = valid_o & ready_i;

    // Bit timer is a down-counter; each state samples at terminal count.
    always_comb begin
        state_nxt      = state;
        clk_cnt_nxt    = clk_cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift_reg;
        parity_bad_nxt = parity_bad;
        deliver        = 1'b0;
        frame_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt      = START;
                    clk_cnt_nxt    = HALF_LOAD;
                    bit_cnt_nxt    = '0;
                    parity_bad_nxt = 1'b0;
                end
            end
            START: begin
                if (tc) begin
                    clk_cnt_nxt = FULL_LOAD;
                    state_nxt   = rxs ? IDLE : DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt - 1'b1;
                end
            end
            DATA: begin
                if (tc) begin
                    shift_nxt[bit_cnt] = rxs;
                    bit_cnt_nxt        = bit_cnt + 1'b1;
                    clk_cnt_nxt        = FULL_LOAD;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = AFTER_DATA;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt - 1'b1;
                end
            end
            PARITY: begin
                if (tc) begin
                    parity_bad_nxt = (rxs != ((^shift_reg) ^ PARITY_SENSE));
                    clk_cnt_nxt    = FULL_LOAD;
                    state_nxt      = STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt - 1'b1;
                end
            end
            STOP: begin
                if (tc) begin
                    if (rxs) begin
                        deliver   = !parity_bad;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = RECOVER;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt - 1'b1;
                end
            end
            RECOVER: begin
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_bad  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            clk_cnt     <= clk_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_reg   <= shift_nxt;
            parity_bad  <= parity_bad_nxt;
            frame_err_o <= frame_err_nxt;
        end
    end

    // A delivery coinciding with an accept replaces the byte without an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (deliver) begin
                if (!valid_o || accept) begin
                    data_o  <= shift_reg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (accept) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= (state == STOP) && tc && parity_bad;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: a vector table of single
// frames plus hand-written sequences for handshake, glitch, break, overrun and reset.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int perr_cnt = 0;
    int acc_cnt  = 0;
    logic [7:0] acc_log [0:63];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always @(negedge clk) begin
        if (frame_err_o)  ferr_cnt <= ferr_cnt + 1;
        if (overrun_o)    ovr_cnt  <= ovr_cnt + 1;
        if (parity_err_o) perr_cnt <= perr_cnt + 1;
        if (valid_o && ready_i) begin
            acc_log[acc_cnt % 64] <= data_o;
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len,
                              input logic par_en, input logic par);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        if (par_en) begin
            rxd = par;
            tick(CPB);
        end
        rxd = stop;
        tick(stop_len);
        rxd = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1, CPB, PAR_EN, ^b);
    endtask

    task automatic clear_valid();
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        int base_f, base_o, base_p, base_a, bad;

        vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
        vecs[5] = '{8'h96, 1'b0, 1'b0, 8'h00, 1};

        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_ferr", 32'(frame_err_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        check("rst_perr", 32'(parity_err_o), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        tick(5);

        for (int v = 0; v < 6; v++) begin
            base_f = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, CPB, PAR_EN, ^vecs[v].data);
            tick(20);
            check($sformatf("vec%0d_valid", v), 32'(valid_o), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid)
                check($sformatf("vec%0d_data", v), 32'(data_o), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - base_f), 32'(vecs[v].exp_ferr));
            if (valid_o) clear_valid();
            tick(5);
        end

        // Byte held across 50 cycles without ready, then a one-cycle accept.
        send_good(8'hA5);
        tick(2);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(valid_o === 1'b1 && data_o === 8'hA5)) bad++;
            tick(1);
        end
        check("hold_a5_cycles_bad", 32'(bad), 32'd0);
        clear_valid();
        check("accept_drops_valid", 32'(valid_o), 32'd0);
        tick(5);

        // Short low glitch must be rejected silently.
        base_f = ferr_cnt;
        base_o = ovr_cnt;
        base_p = perr_cnt;
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(30);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_valid", 32'(valid_o), 32'd0);
        check("glitch_flags", 32'((ferr_cnt - base_f) + (ovr_cnt - base_o) + (perr_cnt - base_p)), 32'd0);
        send_good(8'h3C);
        tick(4);
        check("post_glitch_data", 32'(data_o), 32'h3C);
        check("post_glitch_valid", 32'(valid_o), 32'd1);
        clear_valid();
        tick(5);

        // Break: stop bit held low for 40 cycles gives exactly one frame error.
        base_f = ferr_cnt;
        send_frame(8'h3C, 1'b0, 40, PAR_EN, ^8'h3C);
        tick(20);
        check("break_ferr_once", 32'(ferr_cnt - base_f), 32'd1);
        check("break_valid", 32'(valid_o), 32'd0);
        send_good(8'h5A);
        tick(4);
        check("post_break_data", 32'(data_o), 32'h5A);
        check("post_break_valid", 32'(valid_o), 32'd1);
        clear_valid();
        tick(5);

        // Back-to-back frames with no consumer: second byte overruns.
        base_o = ovr_cnt;
        send_good(8'h11);
        send_good(8'h22);
        tick(4);
        check("b2b_overrun", 32'(ovr_cnt - base_o), 32'd1);
        check("b2b_kept_data", 32'(data_o), 32'h11);
        check("b2b_valid", 32'(valid_o), 32'd1);
        clear_valid();
        tick(5);

        // Back-to-back frames with ready held high: both bytes consumed.
        base_o = ovr_cnt;
        base_a = acc_cnt;
        ready_i = 1'b1;
        send_good(8'h11);
        send_good(8'h22);
        tick(4);
        ready_i = 1'b0;
        check("b2b_rdy_count", 32'(acc_cnt - base_a), 32'd2);
        check("b2b_rdy_byte0", 32'(acc_log[base_a % 64]), 32'h11);
        check("b2b_rdy_byte1", 32'(acc_log[(base_a + 1) % 64]), 32'h22);
        check("b2b_rdy_overrun", 32'(ovr_cnt - base_o), 32'd0);
        tick(5);

        // Reset during data bit 3 drops a pending byte and the frame in flight.
        send_good(8'h42);
        tick(4);
        check("pre_reset_valid", 32'(valid_o), 32'd1);
        base_f = ferr_cnt;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b0;
            tick(CPB);
        end
        rxd = 1'b1;
        tick(8);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_reset_valid", 32'(valid_o), 32'd0);
        check("mid_reset_state", 32'(dut.state), 32'(IDLE));
        tick(8 + CPB * 6 + 32);
        check("post_reset_quiet", 32'(valid_o), 32'd0);
        check("post_reset_ferr", 32'(ferr_cnt - base_f), 32'd0);
        send_good(8'hC3);
        tick(4);
        check("post_reset_data", 32'(data_o), 32'hC3);
        check("post_reset_valid", 32'(valid_o), 32'd1);
        clear_valid();
        tick(5);

`ifdef UART_RX_PARITY_EN
        base_p = perr_cnt;
        send_frame(8'h01, 1'b1, CPB, 1'b1, 1'b0);
        tick(4);
        check("par_bad_perr", 32'(perr_cnt - base_p), 32'd1);
        check("par_bad_valid", 32'(valid_o), 32'd0);
        tick(5);
        base_p = perr_cnt;
        send_frame(8'h01, 1'b1, CPB, 1'b1, 1'b1);
        tick(4);
        check("par_good_perr", 32'(perr_cnt - base_p), 32'd0);
        check("par_good_data", 32'(data_o), 32'h01);
        check("par_good_valid", 32'(valid_o), 32'd1);
        clear_valid();
        tick(5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
